// File: rtl/hub75_pkg.sv
// Shared types, geometry constants and derived widths for the HUB75 panel driver.
package hub75_pkg;

    localparam int PANEL_WIDTH = 64;
    localparam int SCAN_ROWS   = 16;
    localparam int COLOR_DEPTH = 6;
    localparam int BASE_TIME   = 8;

    localparam int COL_W    = $clog2(PANEL_WIDTH);
    localparam int ROW_W    = $clog2(SCAN_ROWS);
    localparam int PLANE_W  = $clog2(COLOR_DEPTH);
    localparam int MAX_DISP = BASE_TIME << (COLOR_DEPTH - 1);
    localparam int CNT_W    = $clog2((MAX_DISP > 2 * PANEL_WIDTH) ? MAX_DISP : 2 * PANEL_WIDTH);

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_ROWSEL  = 2'd2,
        ST_DISPLAY = 2'd3
    } state_e;

    // Last in-state count of the display window for a bit-plane (length BASE_TIME << plane).
    function automatic logic [CNT_W-1:0] display_last(input logic [PLANE_W-1:0] plane);
        return CNT_W'((BASE_TIME << plane) - 1);
    endfunction

endpackage

// File: rtl/hub75_pattern_gen.sv
// Combinational test-pattern source: one RGB bit per lane for the current column, row, plane and frame.
module hub75_pattern_gen
    import hub75_pkg::*;
(
    input  logic [ROW_W-1:0]       row,
    input  logic [COL_W-1:0]       col,
    input  logic [PLANE_W-1:0]     plane,
    input  logic [COLOR_DEPTH-1:0] frame,
    input  logic                   selection_latched,
    output logic [11:0]            data
);

    logic [2:0] lane_s [4];

    // Per-lane bit selection: gradient (column / absolute row / frame) or full white.
    always_comb begin
        logic [COLOR_DEPTH-1:0] r_val;
        logic [COLOR_DEPTH-1:0] g_val;
        logic [COLOR_DEPTH-1:0] b_val;
        r_val = COLOR_DEPTH'(col);
        b_val = frame;
        g_val = '0;
        for (int l = 0; l < 4; l++) begin
            g_val = COLOR_DEPTH'(l * SCAN_ROWS + int'(row));
            if (selection_latched) begin
                lane_s[l] = 3'b111;
            end else begin
                lane_s[l] = {r_val[plane], g_val[plane], b_val[plane]};
            end
        end
    end

    assign data = {lane_s[0], lane_s[1], lane_s[2], lane_s[3]};

endmodule

// File: rtl/hub75_top.sv
// HUB75 panel driver: shift/latch/row-select/display sequencer with binary-coded modulation.
module hub75_top
    import hub75_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic selection,
    output logic r1,
    output logic g1,
    output logic b1,
    output logic r2,
    output logic g2,
    output logic b2,
    output logic r3,
    output logic g3,
    output logic b3,
    output logic r4,
    output logic g4,
    output logic b4,
    output logic clk_out,
    output logic lat,
    output logic blank,
    output logic row_clk,
    output logic row_data
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PLANE_W-1:0]     plane_q, plane_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COLOR_DEPTH-1:0] frame_q, frame_d;
    logic                   sel_q, sel_d;
    logic [11:0]            rgb_q, rgb_d;
    logic                   clk_out_q, clk_out_d;
    logic                   lat_q, lat_d;
    logic                   blank_q, blank_d;
    logic                   row_clk_q, row_clk_d;
    logic                   row_data_q, row_data_d;

    logic                   frame_start_s;
    logic                   sel_eff_s;
    logic [COL_W-1:0]       col_s;
    logic [11:0]            pat_data_s;

    // Selection is only taken at the very first shift cycle of a frame so a frame never tears.
    assign frame_start_s = (state_q == ST_SHIFT) && (cnt_q == '0) && (plane_q == '0) && (row_q == '0);
    assign sel_eff_s     = frame_start_s ? selection : sel_q;
    assign col_s         = cnt_q[COL_W:1];

    hub75_pattern_gen u_pattern (
        .row               (row_q),
        .col               (col_s),
        .plane             (plane_q),
        .frame             (frame_q),
        .selection_latched (sel_eff_s),
        .data              (pat_data_s)
    );

    // Sequencer next-state, counter advance and next output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        plane_d    = plane_q;
        row_d      = row_q;
        frame_d    = frame_q;
        sel_d      = sel_eff_s;
        rgb_d      = rgb_q;
        clk_out_d  = 1'b0;
        lat_d      = 1'b0;
        blank_d    = 1'b1;
        row_clk_d  = 1'b0;
        row_data_d = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                clk_out_d = cnt_q[0];
                rgb_d     = pat_data_s;
                if (cnt_q == CNT_W'(2 * PANEL_WIDTH - 1)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_LATCH: begin
                lat_d = (cnt_q == '0);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = (plane_q == '0) ? ST_ROWSEL : ST_DISPLAY;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            ST_ROWSEL: begin
                case (cnt_q)
                    CNT_W'(0): row_data_d = (row_q == '0);
                    CNT_W'(1): begin
                        row_data_d = row_data_q;
                        row_clk_d  = 1'b1;
                    end
                    default:   row_data_d = 1'b0;
                endcase
                if (cnt_q == CNT_W'(2)) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ROWSEL;
                end
            end
            ST_DISPLAY: begin
                blank_d = 1'b0;
                if (cnt_q == display_last(plane_q)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    if (plane_q == PLANE_W'(COLOR_DEPTH - 1)) begin
                        plane_d = '0;
                        if (row_q == ROW_W'(SCAN_ROWS - 1)) begin
                            row_d   = '0;
                            frame_d = frame_q + COLOR_DEPTH'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                    end
                end else begin
                    state_d = ST_DISPLAY;
                end
            end
            default: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_SHIFT;
            cnt_q      <= '0;
            plane_q    <= '0;
            row_q      <= '0;
            frame_q    <= '0;
            sel_q      <= 1'b0;
            rgb_q      <= 12'h000;
            clk_out_q  <= 1'b0;
            lat_q      <= 1'b0;
            blank_q    <= 1'b1;
            row_clk_q  <= 1'b0;
            row_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            sel_q      <= sel_d;
            rgb_q      <= rgb_d;
            clk_out_q  <= clk_out_d;
            lat_q      <= lat_d;
            blank_q    <= blank_d;
            row_clk_q  <= row_clk_d;
            row_data_q <= row_data_d;
        end
    end

    assign {r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4} = rgb_q;
    assign clk_out  = clk_out_q;
    assign lat      = lat_q;
    assign blank    = blank_q;
    assign row_clk  = row_clk_q;
    assign row_data = row_data_q;

endmodule

// File: tb/tb_hub75_top.sv
// Directed bench for hub75_top: reset, shift/latch/row-select timing, BCM windows and pattern content.
module tb_hub75_top;

    logic clk = 1'b0;
    logic rst;
    logic selection;
    logic r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4;
    logic clk_out, lat, blank, row_clk, row_data;

    hub75_top dut (
        .clk(clk), .rst(rst), .selection(selection),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .r3(r3), .g3(g3), .b3(b3), .r4(r4), .g4(g4), .b4(b4),
        .clk_out(clk_out), .lat(lat), .blank(blank),
        .row_clk(row_clk), .row_data(row_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    logic [11:0] col_word;
    assign col_word = {r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4};

    logic [11:0] rise_data [$];
    int          lat_cyc   [$];
    int          lat_len   [$];
    int          rclk_cyc  [$];
    logic        rclk_dat  [$];
    int          win_len   [$];

    logic prev_clk   = 1'b0;
    logic prev_lat   = 1'b0;
    logic prev_rclk  = 1'b0;
    logic prev_blank = 1'b1;
    int   lat_run    = 0;
    int   blank_run  = 0;
    bit   blank_low_pre_lat = 1'b0;

    // Count clock edges since reset release.
    always @(posedge clk) begin
        if (mon_en) cyc <= cyc + 1;
    end

    // Event recorder, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_out && !prev_clk) rise_data.push_back(col_word);
            if (lat && !prev_lat) lat_cyc.push_back(cyc);
            if (lat) lat_run++;
            else if (prev_lat) begin
                lat_len.push_back(lat_run);
                lat_run = 0;
            end
            if (row_clk && !prev_rclk) begin
                rclk_cyc.push_back(cyc);
                rclk_dat.push_back(row_data);
            end
            if (!blank) blank_run++;
            else if (!prev_blank) begin
                win_len.push_back(blank_run);
                blank_run = 0;
            end
            if (!blank && lat_cyc.size() == 0) blank_low_pre_lat = 1'b1;
            prev_clk   = clk_out;
            prev_lat   = lat;
            prev_rclk  = row_clk;
            prev_blank = blank;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent pattern model indexed by clk_out rise number (frame, row, plane, column order).
    function automatic logic [11:0] model(input int idx);
        int frame, row, plane, col, g;
        logic [11:0] w;
        frame = idx / 6144;
        row   = (idx / 384) % 16;
        plane = (idx / 64) % 6;
        col   = idx % 64;
        w     = 12'h000;
        for (int l = 0; l < 4; l++) begin
            g = (l * 16 + row) % 64;
            w[11 - 3 * l] = 1'((col >> plane) & 1);
            w[10 - 3 * l] = 1'((g >> plane) & 1);
            w[9 - 3 * l]  = 1'(((frame % 64) >> plane) & 1);
        end
        return w;
    endfunction

    initial begin
        rst       = 1'b0;
        selection = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_blank",    32'(blank),    32'd1);
        check("reset_lat",      32'(lat),      32'd0);
        check("reset_clk_out",  32'(clk_out),  32'd0);
        check("reset_row_clk",  32'(row_clk),  32'd0);
        check("reset_row_data", 32'(row_data), 32'd0);
        check("reset_colour",   32'(col_word), 32'h000);

        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("shift_cycle1_clk_out", 32'(clk_out), 32'd0);
        check("shift_cycle1_blank",   32'(blank),   32'd1);
        @(posedge clk); #1;
        check("shift_cycle2_clk_out", 32'(clk_out), 32'd1);

        for (int i = 0; i < 400 && lat_cyc.size() == 0; i++) @(negedge clk);
        check("first_lat_seen",      32'(lat_cyc.size()),    32'd1);
        check("first_lat_cycle",     32'(lat_cyc[0]),        32'd129);
        check("rises_before_lat",    32'(rise_data.size()),  32'd64);
        check("blank_high_in_shift", 32'(blank_low_pre_lat), 32'd0);

        while (cyc < 5000) @(negedge clk);
        @(posedge clk); #1;
        selection = 1'b0;

        for (int i = 0; i < 50000 && rise_data.size() < 12288; i++) @(negedge clk);
        check("two_frames_of_rises", 32'(rise_data.size() >= 12288), 32'd1);

        check("lat_width",         32'(lat_len[0]),             32'd1);
        check("lat_spacing_p0_p1", 32'(lat_cyc[1] - lat_cyc[0]), 32'd141);

        check("row_clk_count",    32'(rclk_cyc.size()), 32'd32);
        check("row_clk0_cycle",   32'(rclk_cyc[0]),     32'd132);
        check("row_clk0_data",    32'(rclk_dat[0]),     32'd1);
        for (int i = 1; i < 16; i++) check($sformatf("row_clk%0d_data", i), 32'(rclk_dat[i]), 32'd0);
        check("row_clk16_data",   32'(rclk_dat[16]),                32'd1);
        check("row_period_0_1",   32'(rclk_cyc[1] - rclk_cyc[0]),   32'd1287);
        check("row_period_15_16", 32'(rclk_cyc[16] - rclk_cyc[15]), 32'd1287);
        check("frame_period",     32'(rclk_cyc[16] - rclk_cyc[0]),  32'd20592);

        for (int i = 0; i < 6; i++) check($sformatf("bcm_window%0d", i), 32'(win_len[i]), 32'(8 << i));
        check("bcm_window_row1_p0", 32'(win_len[6]), 32'd8);

        check("white_first",      32'(rise_data[0]),    32'hFFF);
        check("white_last_f0",    32'(rise_data[6143]), 32'hFFF);
        check("grad_f1_r0_c0",    32'(rise_data[6144]), 32'h249);
        check("grad_f1_r0_c1",    32'(rise_data[6145]), 32'hB6D);
        check("grad_f1_r1_c0",    32'(rise_data[6528]), 32'h6DB);
        for (int i = 0; i < 12288; i++) begin
            check($sformatf("pattern_rise%0d", i), 32'(rise_data[i]),
                  (i < 6144) ? 32'hFFF : 32'(model(i)));
        end

        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset_blank",   32'(blank),    32'd1);
        check("midrun_reset_lat",     32'(lat),      32'd0);
        check("midrun_reset_clk_out", 32'(clk_out),  32'd0);
        check("midrun_reset_row_clk", 32'(row_clk),  32'd0);
        check("midrun_reset_colour",  32'(col_word), 32'h000);
        rst = 1'b1;
        @(posedge clk); #1;
        check("restart_cycle1_clk_out", 32'(clk_out), 32'd0);
        @(posedge clk); #1;
        check("restart_cycle2_clk_out", 32'(clk_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
